button_shift_input: RTL and testbench

//  User-input side of the LED board path: samples two raw pushbuttons,

---
 rtl/led_board_pkg.sv | 16 +
 rtl/button_debouncer.sv | 84 ++++++++
 rtl/button_shift_input.sv | 49 ++++
 tb/tb_button_shift_input.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_board_pkg.sv
// Shared types and constants for the LED board button path.
package led_board_pkg;

    localparam int LED_WIDTH = 8;

    localparam logic [LED_WIDTH-1:0] DEFAULT_INITIAL_LEDS = 8'h1F;

    // Debouncer FSM states
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_t;

endpackage

// File: rtl/button_debouncer.sv
// One pushbutton: 2-flop synchroniser, debounce FSM with stability counter,
// and a registered one-cycle pulse per clean press.
module button_debouncer
    import led_board_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    deb_state_t       state;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser; the FSM only ever looks at sync_p1
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce FSM: a level must persist DEBOUNCE_CYCLES clocks to be accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            press_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync_p1) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    // A drop back to 0 is a bounce: abandon without pulsing
                    if (!sync_p1) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state       <= PRESSED;
                        press_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    // Holding never re-pulses; only a release moves us on
                    if (!sync_p1) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    // Going high again is release bounce, not a new press
                    if (sync_p1) begin
                        state <= PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_shift_input.sv
// Top level: two debounced buttons rotate an 8-bit LED pattern one step per
// press; simultaneous left and right presses cancel each other.
module button_shift_input
    import led_board_pkg::*;
#(
    parameter int                   DEBOUNCE_CYCLES = 500_000,
    parameter logic [LED_WIDTH-1:0] INITIAL_LEDS    = DEFAULT_INITIAL_LEDS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_left,
    input  logic                 btn_right,
    output logic [LED_WIDTH-1:0] leds,
    output logic                 left_pulse,
    output logic                 right_pulse
);

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_left (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_left),
        .press_pulse(left_pulse)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_right (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_right),
        .press_pulse(right_pulse)
    );

    // Pattern register: rotate once on each registered command pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            leds <= INITIAL_LEDS;
        end else begin
            case ({left_pulse, right_pulse})
                2'b10:   leds <= {leds[LED_WIDTH-2:0], leds[LED_WIDTH-1]};
                2'b01:   leds <= {leds[0], leds[LED_WIDTH-1:1]};
                default: leds <= leds;
            endcase
        end
    end

endmodule

// File: tb/tb_button_shift_input.sv
// Directed + randomised bench for button_shift_input with a level/run-length
// reference model of the debounce behaviour.
module tb_button_shift_input;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic [7:0] leds;
    logic       left_pulse;
    logic       right_pulse;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: synchronised view, accepted level, run length of
    // disagreeing samples, pending pulse, and the pattern
    logic       m_s1 [2];
    logic       m_s2 [2];
    logic       m_lvl [2];
    int         m_run [2];
    logic       m_pulse [2];
    logic [7:0] m_leds;

    button_shift_input #(
        .DEBOUNCE_CYCLES(D),
        .INITIAL_LEDS   (8'h1F)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .leds       (leds),
        .left_pulse (left_pulse),
        .right_pulse(right_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rotl(input logic [7:0] v);
        return 8'(((v << 1) | (v >> 7)) & 8'hFF);
    endfunction

    function automatic logic [7:0] rotr(input logic [7:0] v);
        return 8'(((v >> 1) | (v << 7)) & 8'hFF);
    endfunction

    task automatic model_edge(input logic raw_l, input logic raw_r, input logic r);
        logic raw [2];
        logic new_pulse [2];
        raw[0] = raw_l;
        raw[1] = raw_r;
        if (r) begin
            m_leds = 8'h1F;
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 1'b0; m_s2[b] = 1'b0; m_lvl[b] = 1'b0;
                m_run[b] = 0; m_pulse[b] = 1'b0;
            end
        end else begin
            if (m_pulse[0] && !m_pulse[1]) m_leds = rotl(m_leds);
            else if (m_pulse[1] && !m_pulse[0]) m_leds = rotr(m_leds);
            for (int b = 0; b < 2; b++) begin
                new_pulse[b] = 1'b0;
                // A level is accepted once it disagrees for D+1 consecutive edges
                if (m_s2[b] != m_lvl[b]) begin
                    m_run[b]++;
                    if (m_run[b] == D + 1) begin
                        m_lvl[b] = m_s2[b];
                        m_run[b] = 0;
                        new_pulse[b] = m_lvl[b];
                    end
                end else begin
                    m_run[b] = 0;
                end
                m_s2[b] = m_s1[b];
                m_s1[b] = raw[b];
                m_pulse[b] = new_pulse[b];
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_assert++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, compare after the edge
    task automatic step(input logic l, input logic r, input logic rs);
        btn_left  = l;
        btn_right = r;
        rst       = rs;
        @(posedge clk);
        model_edge(l, r, rs);
        #1;
        chk("leds", leds, m_leds);
        chk("left_pulse", {7'd0, left_pulse}, {7'd0, m_pulse[0]});
        chk("right_pulse", {7'd0, right_pulse}, {7'd0, m_pulse[1]});
    endtask

    int         lp_cnt, rp_cnt, lp_at, both_seen, hold;
    logic [7:0] exp_seq [8];
    logic       rl, rr;

    initial begin
        exp_seq[0] = 8'h3E; exp_seq[1] = 8'h7C; exp_seq[2] = 8'hF8; exp_seq[3] = 8'hF1;
        exp_seq[4] = 8'hE3; exp_seq[5] = 8'hC7; exp_seq[6] = 8'h8F; exp_seq[7] = 8'h1F;
        m_leds = 8'h00;
        for (int b = 0; b < 2; b++) begin
            m_s1[b] = 1'b0; m_s2[b] = 1'b0; m_lvl[b] = 1'b0; m_run[b] = 0; m_pulse[b] = 1'b0;
        end

        // 1: reset, then idle
        step(0, 0, 1);
        step(0, 0, 1);
        chk("reset_leds", leds, 8'h1F);
        chk("reset_pulses", {6'd0, left_pulse, right_pulse}, 8'h00);
        lp_cnt = 0; rp_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step(0, 0, 0);
            lp_cnt += int'(left_pulse); rp_cnt += int'(right_pulse);
        end
        chk("idle_no_pulse", 8'(lp_cnt + rp_cnt), 8'd0);

        // 2: clean left press held 40 clocks; edge k is i=0
        lp_cnt = 0; lp_at = -1;
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 0);
            if (left_pulse) begin lp_cnt++; lp_at = i; end
            if (i == 7) chk("left_k7_leds", leds, 8'h3E);
        end
        chk("left_one_pulse", 8'(lp_cnt), 8'd1);
        chk("left_pulse_at_k6", 8'(lp_at), 8'd6);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0);
            lp_cnt += int'(left_pulse);
        end
        chk("left_release_no_pulse", 8'(lp_cnt), 8'd1);
        chk("left_hold_leds", leds, 8'h3E);

        // 3: right press with bounce, then release bounce
        step(0, 0, 1);
        step(0, 0, 1);
        rp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(((i / 2) % 2) == 0 ? 1'b0 : 1'b0, ((i / 2) % 2) == 0, 0);
            rp_cnt += int'(right_pulse);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0);
            rp_cnt += int'(right_pulse);
        end
        chk("bounce_no_pulse", 8'(rp_cnt), 8'd0);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0);
            rp_cnt += int'(right_pulse);
        end
        chk("right_one_pulse", 8'(rp_cnt), 8'd1);
        chk("right_leds", leds, 8'h8F);
        for (int i = 0; i < 12; i++) begin
            step(0, (i % 3) != 0, 0);
            rp_cnt += int'(right_pulse);
        end
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 0);
            rp_cnt += int'(right_pulse);
        end
        chk("release_bounce_no_pulse", 8'(rp_cnt), 8'd1);

        // 4: eight left presses then eight right presses
        step(0, 0, 1);
        step(0, 0, 1);
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 9; i++) step(1, 0, 0);
            for (int i = 0; i < 10; i++) step(0, 0, 0);
            chk("left_wrap_seq", leds, exp_seq[p]);
        end
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 9; i++) step(0, 1, 0);
            for (int i = 0; i < 10; i++) step(0, 0, 0);
        end
        chk("right_return", leds, 8'h1F);

        // 5: both buttons rise together
        both_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 0);
            if (left_pulse && right_pulse) both_seen++;
        end
        chk("both_same_cycle", 8'(both_seen), 8'd1);
        chk("both_cancel_leds", leds, 8'h1F);
        for (int i = 0; i < 12; i++) step(0, 0, 0);

        // 6: reset while left is mid-debounce, button still held
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        step(1, 0, 1);
        step(1, 0, 1);
        lp_cnt = 0; lp_at = -1;
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 0);
            if (left_pulse) begin lp_cnt++; if (lp_at < 0) lp_at = i; end
        end
        chk("rst_mid_one_pulse", 8'(lp_cnt), 8'd1);
        chk("rst_mid_pulse_at", 8'(lp_at), 8'd6);
        chk("rst_mid_leds", leds, 8'h3E);
        for (int i = 0; i < 10; i++) step(0, 0, 0);

        // Random bouncing stimulus with occasional reset
        rl = 1'b0; rr = 1'b0;
        for (int seg = 0; seg < 150; seg++) begin
            if ($urandom_range(0, 3) == 0) rl = ~rl;
            if ($urandom_range(0, 3) == 0) rr = ~rr;
            hold = int'($urandom_range(1, 8));
            for (int i = 0; i < hold; i++) step(rl, rr, ($urandom_range(0, 199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
